// File: rtl/tensor_instruction_scheduler.sv
// rtl/tensor_instruction_scheduler.sv - instruction FIFO and NOP-inserting issue scheduler for the tensor core
// Optional stall counter output enabled by TENSOR_SCHED_STALL_COUNTER_EN.
module tensor_instruction_scheduler #(
  parameter int FIFO_DEPTH      = 8,
  parameter int OPERATE_LATENCY = 6,
  parameter int BURST_LENGTH    = 5
) (
  input  logic                            clock_in,
  input  logic                            reset_n_in,
  input  logic                            instr_valid_in,
  input  logic [15:0]                     instr_data_in,
  output logic                            instr_ready_out,
  output logic [15:0]                     cpu_instruction_out,
  output logic                            issue_valid_out,
  output logic                            burst_read_active_out,
  output logic                            tensor_busy_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_out,
  output logic                            idle_out
`ifdef TENSOR_SCHED_STALL_COUNTER_EN
  ,
  output logic [15:0]                     stall_cycles_out
`endif
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int OCW = $clog2(OPERATE_LATENCY + 1);
  localparam int BCW = $clog2(BURST_LENGTH + 1);

  localparam logic [CW-1:0]  FULL_LEVEL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  WRITE_NEED  = CW'(BURST_LENGTH + 1);
  localparam logic [OCW-1:0] OP_LOAD     = OCW'(OPERATE_LATENCY - 1);
  localparam logic [BCW-1:0] BURST_LOAD  = BCW'(BURST_LENGTH);

  localparam logic [1:0] ST_ISSUE        = 2'd0;
  localparam logic [1:0] ST_OPERATE_WAIT = 2'd1;
  localparam logic [1:0] ST_BURST_READ   = 2'd2;
  localparam logic [1:0] ST_BURST_WRITE  = 2'd3;

  logic [15:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [1:0]     state, nxt_state;
  logic [OCW-1:0] op_cnt, nxt_op_cnt;
  logic [BCW-1:0] b_cnt, nxt_b_cnt;

  logic [15:0] head;
  logic        empty, push, pop;
  logic        head_operate, head_burst_read, head_burst_write, head_gen_reset;
  logic        gen_reset_issue, busy_nxt, burst_read_nxt;

  assign head             = mem[rd_ptr];
  assign empty            = (count == '0);
  assign instr_ready_out  = (count < FULL_LEVEL);
  assign push             = instr_valid_in && instr_ready_out;
  assign fifo_count_out   = count;
  assign idle_out         = (state == ST_ISSUE) && empty && (op_cnt == '0) && (b_cnt == '0);

  assign head_operate     = (head[1:0] == 2'b10);
  assign head_burst_read  = (head[1:0] == 2'b11) && !head[2];
  assign head_burst_write = (head[1:0] == 2'b11) && head[2];
  assign head_gen_reset   = (head[1:0] == 2'b00) && (head[3:2] == 2'b11);

  always_comb begin
    pop             = 1'b0;
    nxt_state       = state;
    nxt_op_cnt      = op_cnt;
    nxt_b_cnt       = b_cnt;
    gen_reset_issue = 1'b0;
    busy_nxt        = 1'b0;
    burst_read_nxt  = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (!empty) begin
          // A burst write only starts once every data word is already queued.
          if (head_burst_write) begin
            if (count >= WRITE_NEED) begin
              pop       = 1'b1;
              nxt_b_cnt = BURST_LOAD;
              nxt_state = ST_BURST_WRITE;
            end
          end else begin
            pop = 1'b1;
            if (head_operate) begin
              nxt_op_cnt = OP_LOAD;
              nxt_state  = ST_OPERATE_WAIT;
            end else if (head_burst_read) begin
              nxt_b_cnt = BURST_LOAD;
              nxt_state = ST_BURST_READ;
            end else if (head_gen_reset) begin
              nxt_op_cnt      = '0;
              nxt_b_cnt       = '0;
              gen_reset_issue = 1'b1;
            end
          end
        end
      end
      ST_OPERATE_WAIT, ST_BURST_READ: begin
        // A queued GENERIC RESET cuts any wait short.
        if (!empty && head_gen_reset) begin
          pop             = 1'b1;
          nxt_op_cnt      = '0;
          nxt_b_cnt       = '0;
          gen_reset_issue = 1'b1;
          nxt_state       = ST_ISSUE;
        end else if (state == ST_OPERATE_WAIT) begin
          busy_nxt   = 1'b1;
          nxt_op_cnt = (op_cnt == '0) ? '0 : op_cnt - OCW'(1);
          if (op_cnt <= OCW'(1)) nxt_state = ST_ISSUE;
        end else begin
          burst_read_nxt = 1'b1;
          nxt_b_cnt      = (b_cnt == '0) ? '0 : b_cnt - BCW'(1);
          if (b_cnt <= BCW'(1)) nxt_state = ST_ISSUE;
        end
      end
      default: begin
        pop       = !empty;
        nxt_b_cnt = (b_cnt == '0) ? '0 : b_cnt - BCW'(1);
        if (b_cnt <= BCW'(1)) nxt_state = ST_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (push) mem[wr_ptr] <= instr_data_in;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      state                 <= ST_ISSUE;
      op_cnt                <= '0;
      b_cnt                 <= '0;
      cpu_instruction_out   <= 16'h0000;
      issue_valid_out       <= 1'b0;
      tensor_busy_out       <= 1'b0;
      burst_read_active_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      state                 <= nxt_state;
      op_cnt                <= nxt_op_cnt;
      b_cnt                 <= nxt_b_cnt;
      cpu_instruction_out   <= pop ? head : 16'h0000;
      issue_valid_out       <= pop;
      tensor_busy_out       <= busy_nxt;
      burst_read_active_out <= burst_read_nxt;
    end
  end

`ifdef TENSOR_SCHED_STALL_COUNTER_EN
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      stall_cycles_out <= 16'h0000;
    end else if (gen_reset_issue) begin
      stall_cycles_out <= 16'h0000;
    end else if (!empty && !pop && (stall_cycles_out != 16'hFFFF)) begin
      stall_cycles_out <= stall_cycles_out + 16'h0001;
    end
  end
`endif

endmodule
